// File: rtl/npn_pkg.sv
// Shared definitions for the NPN canonicaliser.
//   - Width constants for the largest supported function (4 inputs).
//   - FSM state type.
//   - tuple_is_perm: true when the first n 2-bit digits of a tuple are distinct and < n.
//   - tt_transform: applies input permutation + input negation to a truth table.
//   - Per-N latency constants (accept edge to out_valid high).
package npn_pkg;

  localparam int unsigned MaxInputs = 4;
  localparam int unsigned MaxTtW    = 16;
  localparam int unsigned MaxIdxW   = 2;

  localparam int unsigned C_N2 = 10;
  localparam int unsigned C_N3 = 69;
  localparam int unsigned C_N4 = 616;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  // Digits are packed as 2-bit fields, digit i in bits [2*i +: 2].
  function automatic logic tuple_is_perm(input logic [MaxIdxW*MaxInputs-1:0] tuple,
                                         input int n);
    logic [MaxInputs-1:0] seen;
    logic [MaxIdxW-1:0]   d;
    logic                 ok;
    seen = '0;
    ok   = 1'b1;
    for (int i = 0; i < int'(MaxInputs); i++) begin
      if (i < n) begin
        d = tuple[MaxIdxW*i +: MaxIdxW];
        if ({30'd0, d} >= n) begin
          ok = 1'b0;
        end else if (seen[d]) begin
          ok = 1'b0;
        end else begin
          seen[d] = 1'b1;
        end
      end
    end
    return ok;
  endfunction

  // T[m] = F[m'] where m'[i] = m[perm[i]] ^ neg[i]; rows beyond 2^n stay zero.
  function automatic logic [MaxTtW-1:0] tt_transform(input logic [MaxTtW-1:0]            tt,
                                                     input logic [MaxIdxW*MaxInputs-1:0] perm,
                                                     input logic [MaxInputs-1:0]         neg,
                                                     input int                           n);
    logic [MaxTtW-1:0]    res;
    logic [MaxInputs-1:0] m;
    logic [MaxInputs-1:0] mp;
    res = '0;
    for (int k = 0; k < int'(MaxTtW); k++) begin
      m  = 4'(k);
      mp = '0;
      for (int i = 0; i < int'(MaxInputs); i++) begin
        if (i < n) begin
          mp[i] = m[perm[MaxIdxW*i +: MaxIdxW]] ^ neg[i];
        end
      end
      if (k < (1 << n)) begin
        res[k] = tt[mp];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/npn_tt_transform.sv
// Combinational truth-table transform for one (perm, neg) pair.
//   in_tt : source truth table
//   perm  : perm[i] in bits [i*IDX_W +: IDX_W]
//   neg   : input-negation mask
//   t     : transformed table T
//   t_n   : its output-negated counterpart ~T
module npn_tt_transform
  import npn_pkg::*;
#(
  parameter int unsigned  NUM_INPUTS = 4,
  localparam int unsigned TT_W       = 1 << NUM_INPUTS,
  localparam int unsigned IDX_W      = ($clog2(NUM_INPUTS) > 1) ? $clog2(NUM_INPUTS) : 1
) (
  input  logic [TT_W-1:0]             in_tt,
  input  logic [NUM_INPUTS*IDX_W-1:0] perm,
  input  logic [NUM_INPUTS-1:0]       neg,
  output logic [TT_W-1:0]             t,
  output logic [TT_W-1:0]             t_n
);

  logic [MaxIdxW*MaxInputs-1:0] perm_pad;
  logic [MaxTtW-1:0]            t_full;
  logic                         unused_t_full;

  always_comb begin
    perm_pad = '0;
    for (int i = 0; i < int'(NUM_INPUTS); i++) begin
      perm_pad[MaxIdxW*i +: MaxIdxW] = MaxIdxW'(perm[i*IDX_W +: IDX_W]);
    end
    t_full = tt_transform(MaxTtW'(in_tt), perm_pad, MaxInputs'(neg), int'(NUM_INPUTS));
  end

  // Rows above TT_W are always zero for small instances.
  assign unused_t_full = ^t_full;

  assign t   = t_full[TT_W-1:0];
  assign t_n = ~t_full[TT_W-1:0];

endmodule

// File: rtl/npn_canon_seq.sv
// Sequential NPN canonicaliser. Walks every permutation tuple and every
// input-negation mask (one mask per cycle), compares T and ~T against the
// running minimum, and reports the smallest table plus the transform that
// first produced it.
//   clk, rst_n          : clock, async active-low reset
//   in_valid/in_ready   : request handshake (ready only in IDLE)
//   in_tt               : truth table, bit m = f(x) with x_i = bit i of m
//   out_valid/out_ready : result handshake (valid only in DONE)
//   canon_tt            : minimum transformed table
//   perm_out            : perm[i] in bits [i*IDX_W +: IDX_W]
//   neg_out, out_neg    : input-negation mask, output-negation flag
module npn_canon_seq
  import npn_pkg::*;
#(
  parameter int unsigned  NUM_INPUTS = 4,
  localparam int unsigned TT_W       = 1 << NUM_INPUTS,
  localparam int unsigned IDX_W      = ($clog2(NUM_INPUTS) > 1) ? $clog2(NUM_INPUTS) : 1,
  localparam int unsigned PERM_W     = NUM_INPUTS * IDX_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [TT_W-1:0]       in_tt,
  output logic                  in_ready,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [TT_W-1:0]       canon_tt,
  output logic [PERM_W-1:0]     perm_out,
  output logic [NUM_INPUTS-1:0] neg_out,
  output logic                  out_neg
);

  if (NUM_INPUTS < 2 || NUM_INPUTS > 4) begin : g_bad_num_inputs
    $error("npn_canon_seq: NUM_INPUTS must be in 2..4");
  end

  state_e                state_q, state_d;
  logic [TT_W-1:0]       tt_q, tt_d;
  logic [PERM_W-1:0]     tuple_q, tuple_d;
  logic [NUM_INPUTS-1:0] mask_q, mask_d;
  logic [TT_W-1:0]       best_q, best_d;
  logic                  found_q, found_d;
  logic [PERM_W-1:0]     best_perm_q, best_perm_d;
  logic [NUM_INPUTS-1:0] best_neg_q, best_neg_d;
  logic                  best_oneg_q, best_oneg_d;
  logic [TT_W-1:0]       canon_q, canon_d;
  logic [PERM_W-1:0]     perm_q, perm_d;
  logic [NUM_INPUTS-1:0] neg_q, neg_d;
  logic                  oneg_q, oneg_d;

  logic [TT_W-1:0]              t, t_n;
  logic [MaxIdxW*MaxInputs-1:0] tuple_pad;
  logic                         tuple_ok;
  logic                         tuple_last;
  logic                         mask_last;
  logic [PERM_W-1:0]            tuple_inc;
  logic                         carry;

  logic [TT_W-1:0]       cand_tt;
  logic                  cand_found;
  logic [PERM_W-1:0]     cand_perm;
  logic [NUM_INPUTS-1:0] cand_neg;
  logic                  cand_oneg;

  npn_tt_transform #(
    .NUM_INPUTS(NUM_INPUTS)
  ) u_transform (
    .in_tt(tt_q),
    .perm (tuple_q),
    .neg  (mask_q),
    .t    (t),
    .t_n  (t_n)
  );

  // Tuple classification and mixed-radix (base N) increment, last digit fastest.
  always_comb begin
    tuple_pad  = '0;
    tuple_last = 1'b1;
    for (int i = 0; i < int'(NUM_INPUTS); i++) begin
      tuple_pad[MaxIdxW*i +: MaxIdxW] = MaxIdxW'(tuple_q[i*IDX_W +: IDX_W]);
      if (tuple_q[i*IDX_W +: IDX_W] != IDX_W'(NUM_INPUTS - 1)) begin
        tuple_last = 1'b0;
      end
    end
    tuple_ok  = tuple_is_perm(tuple_pad, int'(NUM_INPUTS));
    mask_last = &mask_q;

    tuple_inc = tuple_q;
    carry     = 1'b1;
    for (int i = int'(NUM_INPUTS) - 1; i >= 0; i--) begin
      if (carry) begin
        if (tuple_q[i*IDX_W +: IDX_W] == IDX_W'(NUM_INPUTS - 1)) begin
          tuple_inc[i*IDX_W +: IDX_W] = '0;
        end else begin
          tuple_inc[i*IDX_W +: IDX_W] = tuple_q[i*IDX_W +: IDX_W] + IDX_W'(1);
          carry                       = 1'b0;
        end
      end
    end
  end

  // T is tried before ~T; only a strictly smaller table displaces the best,
  // so ties keep the earliest transform.
  always_comb begin
    cand_tt    = best_q;
    cand_found = found_q;
    cand_perm  = best_perm_q;
    cand_neg   = best_neg_q;
    cand_oneg  = best_oneg_q;
    if (state_q == StRun && tuple_ok) begin
      if (!found_q || t < best_q) begin
        cand_tt    = t;
        cand_found = 1'b1;
        cand_perm  = tuple_q;
        cand_neg   = mask_q;
        cand_oneg  = 1'b0;
      end
      if (t_n < cand_tt) begin
        cand_tt    = t_n;
        cand_found = 1'b1;
        cand_perm  = tuple_q;
        cand_neg   = mask_q;
        cand_oneg  = 1'b1;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    tt_d        = tt_q;
    tuple_d     = tuple_q;
    mask_d      = mask_q;
    best_d      = best_q;
    found_d     = found_q;
    best_perm_d = best_perm_q;
    best_neg_d  = best_neg_q;
    best_oneg_d = best_oneg_q;
    canon_d     = canon_q;
    perm_d      = perm_q;
    neg_d       = neg_q;
    oneg_d      = oneg_q;

    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          tt_d    = in_tt;
          tuple_d = '0;
          mask_d  = '0;
          best_d  = '1;
          found_d = 1'b0;
          state_d = StRun;
        end
      end
      StRun: begin
        best_d      = cand_tt;
        found_d     = cand_found;
        best_perm_d = cand_perm;
        best_neg_d  = cand_neg;
        best_oneg_d = cand_oneg;
        // Invalid tuples take a single cycle; valid ones sweep all masks.
        if (tuple_ok && !mask_last) begin
          mask_d = mask_q + NUM_INPUTS'(1);
        end else begin
          mask_d  = '0;
          tuple_d = tuple_inc;
        end
        if (tuple_last && (!tuple_ok || mask_last)) begin
          canon_d = cand_tt;
          perm_d  = cand_perm;
          neg_d   = cand_neg;
          oneg_d  = cand_oneg;
          state_d = StDone;
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      tt_q        <= '0;
      tuple_q     <= '0;
      mask_q      <= '0;
      best_q      <= '0;
      found_q     <= 1'b0;
      best_perm_q <= '0;
      best_neg_q  <= '0;
      best_oneg_q <= 1'b0;
      canon_q     <= '0;
      perm_q      <= '0;
      neg_q       <= '0;
      oneg_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      tt_q        <= tt_d;
      tuple_q     <= tuple_d;
      mask_q      <= mask_d;
      best_q      <= best_d;
      found_q     <= found_d;
      best_perm_q <= best_perm_d;
      best_neg_q  <= best_neg_d;
      best_oneg_q <= best_oneg_d;
      canon_q     <= canon_d;
      perm_q      <= perm_d;
      neg_q       <= neg_d;
      oneg_q      <= oneg_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign canon_tt  = canon_q;
  assign perm_out  = perm_q;
  assign neg_out   = neg_q;
  assign out_neg   = oneg_q;

endmodule

// File: tb/tb_npn_canon_seq.sv
// Scoreboard bench for npn_canon_seq: a 4-input and a 2-input instance.
// Requests push hand-computed results; per-instance monitors pop and compare
// whenever out_valid rises, including accept-to-valid latency.
module tb_npn_canon_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic        in_valid4, in_ready4, out_valid4, out_ready4, out_neg4;
  logic [15:0] in_tt4, canon4;
  logic [7:0]  perm4;
  logic [3:0]  neg4;

  logic        in_valid2, in_ready2, out_valid2, out_ready2, out_neg2;
  logic [3:0]  in_tt2, canon2;
  logic [1:0]  perm2, neg2;

  npn_canon_seq #(
    .NUM_INPUTS(4)
  ) u_dut4 (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid4),
    .in_tt    (in_tt4),
    .in_ready (in_ready4),
    .out_valid(out_valid4),
    .out_ready(out_ready4),
    .canon_tt (canon4),
    .perm_out (perm4),
    .neg_out  (neg4),
    .out_neg  (out_neg4)
  );

  npn_canon_seq #(
    .NUM_INPUTS(2)
  ) u_dut2 (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid2),
    .in_tt    (in_tt2),
    .in_ready (in_ready2),
    .out_valid(out_valid2),
    .out_ready(out_ready2),
    .canon_tt (canon2),
    .perm_out (perm2),
    .neg_out  (neg2),
    .out_neg  (out_neg2)
  );

  typedef struct {
    logic [15:0] tt;
    logic [7:0]  perm;
    logic [3:0]  neg;
    logic        oneg;
    int          acc;
    int          lat;
  } exp_t;

  exp_t q4[$];
  exp_t q2[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  initial begin : mon4
    logic prev;
    exp_t e;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (out_valid4 && !prev) begin
        if (q4.size() == 0) begin
          chk("n4_unexpected_out_valid", 32'(out_valid4), 32'd0);
        end else begin
          e = q4.pop_front();
          chk("n4_canon", 32'(canon4), 32'(e.tt));
          chk("n4_perm", 32'(perm4), 32'(e.perm));
          chk("n4_neg", 32'(neg4), 32'(e.neg));
          chk("n4_out_neg", 32'(out_neg4), 32'(e.oneg));
          chk("n4_latency", 32'(cyc - e.acc), 32'(e.lat));
        end
      end
      prev = out_valid4;
    end
  end

  initial begin : mon2
    logic prev;
    exp_t e;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (out_valid2 && !prev) begin
        if (q2.size() == 0) begin
          chk("n2_unexpected_out_valid", 32'(out_valid2), 32'd0);
        end else begin
          e = q2.pop_front();
          chk("n2_canon", 32'(canon2), 32'(e.tt));
          chk("n2_perm", 32'(perm2), 32'(e.perm));
          chk("n2_neg", 32'(neg2), 32'(e.neg));
          chk("n2_out_neg", 32'(out_neg2), 32'(e.oneg));
          chk("n2_latency", 32'(cyc - e.acc), 32'(e.lat));
        end
      end
      prev = out_valid2;
    end
  end

  task automatic req4(input logic [15:0] tt, input logic push, input logic [15:0] ett,
                      input logic [7:0] ep, input logic [3:0] en, input logic eo);
    int   n;
    exp_t e;
    n = 0;
    while (!in_ready4 && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("n4_in_ready_before_req", 32'(in_ready4), 32'd1);
    in_tt4    = tt;
    in_valid4 = 1'b1;
    @(posedge clk);
    #1;
    in_valid4 = 1'b0;
    in_tt4    = ~tt;  // table must already be latched
    if (push) begin
      e.tt   = ett;
      e.perm = ep;
      e.neg  = en;
      e.oneg = eo;
      e.acc  = cyc;
      e.lat  = 616;
      q4.push_back(e);
    end
  endtask

  task automatic drain4();
    int n;
    n = 0;
    while (q4.size() != 0 && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("n4_result_within_budget", 32'(q4.size()), 32'd0);
    q4.delete();
    @(posedge clk);
    #1;
  endtask

  initial begin : stim
    exp_t e;
    int   n;
    rst_n      = 1'b0;
    in_valid4  = 1'b0;
    in_tt4     = '0;
    out_ready4 = 1'b1;
    in_valid2  = 1'b0;
    in_tt2     = '0;
    out_ready2 = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready4", 32'(in_ready4), 32'd1);
    chk("rst_out_valid4", 32'(out_valid4), 32'd0);
    chk("rst_canon4", 32'(canon4), 32'd0);
    chk("rst_perm4", 32'(perm4), 32'd0);
    chk("rst_neg4", 32'(neg4), 32'd0);
    chk("rst_out_neg4", 32'(out_neg4), 32'd0);
    chk("rst_in_ready2", 32'(in_ready2), 32'd1);
    chk("rst_out_valid2", 32'(out_valid2), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // N=2 XOR: 4'h6, perm (0,1) -> 2'b10, neg 0, out_neg 0, latency 10.
    in_tt2    = 4'h6;
    in_valid2 = 1'b1;
    @(posedge clk);
    #1;
    in_valid2 = 1'b0;
    in_tt2    = 4'h0;
    e.tt      = 16'h0006;
    e.perm    = 8'h02;
    e.neg     = 4'h0;
    e.oneg    = 1'b0;
    e.acc     = cyc;
    e.lat     = 10;
    q2.push_back(e);

    // Constant one: ~T of the first transform is all zeros.
    req4(16'hFFFF, 1'b1, 16'h0000, 8'hE4, 4'h0, 1'b1);
    n = 0;
    while (q2.size() != 0 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("n2_result_within_budget", 32'(q2.size()), 32'd0);
    drain4();

    // f = x0 under backpressure: ~x3 = 16'h00FF, first at perm (3,0,1,2).
    out_ready4 = 1'b0;
    req4(16'hAAAA, 1'b1, 16'h00FF, 8'h93, 4'h0, 1'b1);
    n = 0;
    while (!out_valid4 && n < 1000) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("bp_out_valid", 32'(out_valid4), 32'd1);
    in_tt4    = 16'h8000;
    in_valid4 = 1'b1;
    repeat (20) begin
      @(negedge clk);
      chk("bp_hold_canon", 32'(canon4), 32'h00FF);
      chk("bp_hold_perm", 32'(perm4), 32'h93);
      chk("bp_hold_neg", 32'(neg4), 32'h0);
      chk("bp_hold_out_neg", 32'(out_neg4), 32'd1);
      chk("bp_hold_out_valid", 32'(out_valid4), 32'd1);
      chk("bp_hold_in_ready", 32'(in_ready4), 32'd0);
    end
    in_valid4  = 1'b0;
    out_ready4 = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_release_out_valid", 32'(out_valid4), 32'd0);
    chk("bp_release_in_ready", 32'(in_ready4), 32'd1);
    chk("bp_release_canon_held", 32'(canon4), 32'h00FF);

    // 4-input AND: 16'h0001 via full input negation.
    req4(16'h8000, 1'b1, 16'h0001, 8'hE4, 4'hF, 1'b0);
    drain4();

    // Reset 300 cycles into a run: nothing may be emitted.
    req4(16'hAAAA, 1'b0, 16'h0000, 8'h00, 4'h0, 1'b0);
    repeat (300) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid4), 32'd0);
    chk("midrst_canon", 32'(canon4), 32'd0);
    chk("midrst_perm", 32'(perm4), 32'd0);
    chk("midrst_neg", 32'(neg4), 32'd0);
    chk("midrst_out_neg", 32'(out_neg4), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("postrst_in_ready", 32'(in_ready4), 32'd1);
    chk("postrst_out_valid", 32'(out_valid4), 32'd0);

    req4(16'h8000, 1'b1, 16'h0001, 8'hE4, 4'hF, 1'b0);
    drain4();
    repeat (5) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/npn_canon_seq.md
Name: npn_canon_seq

Overview:
- Sequential NPN canonicaliser for NUM_INPUTS-input Boolean functions given as truth tables.
- Enumerates every input permutation, input-negation mask and output polarity, one negation mask per cycle. Returns the numerically smallest transformed truth table and the transform that first produced it.
- Generalised, run-time successor to the fixed per-class exact AIG netlists. Feeds the class-lookup and netlist-selection stage.

Parameters:
- NUM_INPUTS, 4, function input count; legal range 2..4 (elaboration error otherwise).
- TT_W, 2**NUM_INPUTS, truth-table width (derived, not overridable).
- IDX_W, max(1,$clog2(NUM_INPUTS)), width of one permutation index (derived).

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  request strobe.
- in_tt  input  TT_W  truth table; bit m = f(x) where x_i = bit i of m.
- in_ready  output  1  high only in IDLE.
- out_valid  output  1  high in DONE.
- out_ready  input  1  result consumed when high with out_valid.
- canon_tt  output  TT_W  minimum transformed table.
- perm_out  output  NUM_INPUTS*IDX_W  perm[i] in bits [i*IDX_W +: IDX_W].
- neg_out  output  NUM_INPUTS  input-negation mask.
- out_neg  output  1  output-negation flag.

Behaviour:
- Reset (asynchronous, rst_n low):
  - state = IDLE.
  - out_valid = 0; canon_tt, perm_out, neg_out, out_neg all 0.
  - in_ready is 1 once state is IDLE.
- Transform definition, for each m in 0..TT_W-1:
  - m' has bit i = (bit perm[i] of m) XOR neg[i].
  - T[m] = F[m'].
  - The candidate pair is T and ~T (output negation).
- Tuple enumeration:
  - A tuple counter holds digits perm[0..N-1], each 0..N-1. perm[N-1] is the fastest-changing digit.
  - The counter starts at all-zero and steps through all N^N tuples.
  - A tuple is valid iff all digits are distinct.
- States:
  - IDLE: in_valid & in_ready latches in_tt, clears the tuple counter and mask, sets best = all-ones with found = 0, then goes to RUN.
  - RUN, invalid tuple: consumes exactly one cycle, then advances the tuple.
  - RUN, valid tuple: one cycle per neg mask, 0..2^N-1 ascending. Each cycle compares T first, then ~T.
    - A candidate replaces best only if strictly less, or if found = 0.
    - Ties keep the earlier candidate.
    - On replacement, perm/neg/out_neg are recorded.
  - RUN ends on the last mask of the last tuple → DONE. That final edge also updates outputs and sets out_valid.
  - DONE: outputs are held stable while out_ready is low. out_valid & out_ready → IDLE and out_valid = 0. Output data holds its last value.
- Latency, from accept edge to out_valid high (C edges):
  - N=2: 10.
  - N=3: 69.
  - N=4: 616.
  - Formula: C = invalid tuples + valid tuples × 2^N.
- in_valid is ignored outside IDLE; no queuing.
- Reset asserted mid-RUN or in DONE aborts immediately to the reset values. No partial result is emitted.
- in_tt changes after acceptance have no effect, because the table is latched.

Decomposition:
- Package npn_pkg holds:
  - Derived width constants.
  - Function tuple_is_perm(tuple).
  - Function tt_transform(tt, perm, neg) implementing the transform definition.
  - Per-N latency constants C_N2 = 10, C_N3 = 69, C_N4 = 616, for use by the bench.
- One sub-module, npn_tt_transform: purely combinational. Takes in_tt, perm and neg, and drives T and ~T. The top-level file keeps the FSM, counters and comparator.

Test Plan:
- N=4: in_tt = 16'hFFFF → canon 16'h0000, perm (0,1,2,3), neg 0, out_neg 1; out_valid exactly 616 edges after accept.
- N=4: in_tt = 16'hAAAA (f = x0) → canon 16'h00FF, perm (3,0,1,2), neg 4'h0, out_neg 1.
- N=4: in_tt = 16'h8000 (4-input AND) → canon 16'h0001, perm (0,1,2,3), neg 4'hF, out_neg 0.
- N=2 instance: in_tt = 4'h6 (XOR) → canon 4'h6, perm (0,1), neg 0, out_neg 0; latency 10.
- Backpressure: hold out_ready = 0 for 20 cycles after out_valid → outputs stable, in_ready = 0, and a new in_valid is ignored. Then out_ready = 1 → IDLE next edge, and a following request is accepted.
- Reset: assert rst_n low at cycle 300 of a N=4 run → out_valid stays 0, all outputs 0, in_ready = 1 after release. Rerun with 16'h8000 → correct result.
